// File: rtl/gesture_pkg.sv
// Shared definitions for the gesture scoring path.
// Holds the frame FSM state enum, a wide signed type used for overflow-free
// intermediate arithmetic, a saturating signed add, the margin clip and the
// class-index width helper.
package gesture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_RANK,
        ST_DECIDE
    } state_e;

    localparam int unsigned WIDE_BITS = 64;

    typedef logic signed [WIDE_BITS-1:0] wide_t;

    // Width of a class index; never narrower than one bit.
    function automatic int unsigned class_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // a + b clamped to the signed range of a 'bits'-wide register.
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned bits);
        wide_t sum;
        wide_t hi;
        wide_t lo;
        sum = a + b;
        hi  = (wide_t'(1) <<< (bits - 1)) - wide_t'(1);
        lo  = -hi - wide_t'(1);
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

    // Best-minus-second margin squeezed into 8 bits.
    function automatic logic [7:0] clip_margin(input wide_t m);
        if (m < 0) begin
            return 8'd0;
        end
        if (m > 255) begin
            return 8'd255;
        end
        return m[7:0];
    endfunction

endpackage

// File: rtl/score_rank_top2.sv
// Sequential best / second-best tracker.
// Scores are presented one per cycle with valid_i; clear_i restarts a ranking.
// A score only displaces the current best when strictly greater, so with
// classes visited in ascending order ties resolve to the lower index.
// Ports: clk, rst (async, active-high), clear_i, valid_i, idx_i, score_i,
//        best_idx_o, best_score_o, second_score_o.
module score_rank_top2 #(
    parameter int unsigned SCORE_BITS = 24,
    parameter int unsigned CLASS_BITS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         valid_i,
    input  logic [CLASS_BITS-1:0]        idx_i,
    input  logic signed [SCORE_BITS-1:0] score_i,
    output logic [CLASS_BITS-1:0]        best_idx_o,
    output logic signed [SCORE_BITS-1:0] best_score_o,
    output logic signed [SCORE_BITS-1:0] second_score_o
);

    logic signed [SCORE_BITS-1:0] best_q;
    logic signed [SCORE_BITS-1:0] second_q;
    logic [CLASS_BITS-1:0]        best_idx_q;
    logic                         have_best_q;
    logic                         have_second_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q        <= '0;
            second_q      <= '0;
            best_idx_q    <= '0;
            have_best_q   <= 1'b0;
            have_second_q <= 1'b0;
        end else if (clear_i) begin
            best_q        <= '0;
            second_q      <= '0;
            best_idx_q    <= '0;
            have_best_q   <= 1'b0;
            have_second_q <= 1'b0;
        end else if (valid_i) begin
            if (!have_best_q || (score_i > best_q)) begin
                // Old best slides down to second place.
                second_q      <= best_q;
                have_second_q <= have_best_q;
                best_q        <= score_i;
                best_idx_q    <= idx_i;
                have_best_q   <= 1'b1;
            end else if (!have_second_q || (score_i > second_q)) begin
                second_q      <= score_i;
                have_second_q <= 1'b1;
            end
        end
    end

    assign best_idx_o     = best_idx_q;
    assign best_score_o   = best_q;
    assign second_score_o = second_q;

endmodule

// File: rtl/gesture_score_engine.sv
// Frame classifier: scans the time-surface once per frame, accumulates a
// saturating multi-class MAC and energy sum, ranks the classes, gates the
// winner on energy and margin and applies multi-frame hysteresis.
// Ports: clk, rst (async, active-high); frame_src_ext/frame_trigger select and
//        provide the frame start; ts_read_*/w_* form the surface and weight
//        read port; busy/frame_overrun report frame status; result_* and
//        gesture_* report the classification; dbg_* expose the last frame.
module gesture_score_engine
    import gesture_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 12_000_000,
    parameter int unsigned FRAME_PERIOD_MS = 10,
    parameter int unsigned GRID_SIZE       = 32,
    parameter int unsigned ADDR_BITS       = 10,
    parameter int unsigned VALUE_BITS      = 8,
    parameter int unsigned WEIGHT_BITS     = 8,
    parameter int unsigned SCORE_BITS      = 24,
    parameter int unsigned NUM_CLASSES     = 4,
    parameter int unsigned CLASS_BITS      = class_bits(NUM_CLASSES),
    parameter int unsigned READ_LATENCY    = 2,
    parameter int unsigned MIN_ENERGY      = 100,
    parameter int unsigned MIN_MARGIN      = 0,
    parameter int unsigned STABLE_FRAMES   = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               frame_src_ext,
    input  logic                               frame_trigger,
    output logic [ADDR_BITS-1:0]               ts_read_addr,
    output logic                               ts_read_enable,
    input  logic [VALUE_BITS-1:0]              ts_read_value,
    output logic [ADDR_BITS-1:0]               w_addr,
    input  logic [NUM_CLASSES*WEIGHT_BITS-1:0] w_data_flat,
    output logic                               busy,
    output logic                               frame_overrun,
    output logic                               result_valid,
    output logic [CLASS_BITS-1:0]              result_class,
    output logic [7:0]                         result_margin,
    output logic                               gesture_valid,
    output logic [CLASS_BITS-1:0]              gesture_class,
    output logic [7:0]                         gesture_confidence,
    output logic [SCORE_BITS-1:0]              dbg_energy,
    output logic [NUM_CLASSES*SCORE_BITS-1:0]  dbg_scores_flat
);

    localparam int unsigned NUM_CELLS    = GRID_SIZE * GRID_SIZE;
    localparam int unsigned TIMER_PERIOD = (CLK_FREQ_HZ / 1000) * FRAME_PERIOD_MS;
    localparam int unsigned TIMER_BITS   = $clog2(TIMER_PERIOD + 1);
    localparam int unsigned DRAIN_BITS   = $clog2(READ_LATENCY + 1);
    localparam int unsigned STREAK_BITS  = $clog2(STABLE_FRAMES + 1);

    localparam logic [ADDR_BITS-1:0]   LAST_ADDR  = ADDR_BITS'(NUM_CELLS - 1);
    localparam logic [CLASS_BITS-1:0]  LAST_CLASS = CLASS_BITS'(NUM_CLASSES - 1);
    localparam logic [STREAK_BITS-1:0] STABLE_N   = STREAK_BITS'(STABLE_FRAMES);

    // FSM and datapath registers
    state_e                        state_q, state_d;
    logic [ADDR_BITS-1:0]          addr_q, addr_d;
    logic                          en_q, en_d;
    logic                          busy_q, busy_d;
    logic [DRAIN_BITS-1:0]         drain_q, drain_d;
    logic [CLASS_BITS-1:0]         rank_idx_q, rank_idx_d;
    logic                          src_sel_q, src_sel_d;
    logic                          overrun_q, overrun_d;
    logic                          rv_q, rv_d;
    logic [CLASS_BITS-1:0]         rcls_q, rcls_d;
    logic [7:0]                    rmargin_q, rmargin_d;
    logic                          gv_q, gv_d;
    logic [CLASS_BITS-1:0]         gcls_q, gcls_d;
    logic [7:0]                    gconf_q, gconf_d;
    logic [SCORE_BITS-1:0]         energy_dbg_q, energy_dbg_d;
    logic [NUM_CLASSES*SCORE_BITS-1:0] scores_dbg_q, scores_dbg_d;
    logic [STREAK_BITS-1:0]        streak_q, streak_d;
    logic [CLASS_BITS-1:0]         last_class_q, last_class_d;

    logic [TIMER_BITS-1:0]         tmr_q;
    logic [READ_LATENCY-1:0]       vld_q;
    logic signed [SCORE_BITS-1:0]  energy_q;

    logic                          tick_c;
    logic                          use_ext_c;
    logic                          trig_c;
    logic                          start_c;
    logic signed [VALUE_BITS:0]    val_s;
    logic signed [SCORE_BITS-1:0]  score_c [NUM_CLASSES];
    logic signed [SCORE_BITS-1:0]  rank_score_c;
    logic [CLASS_BITS-1:0]         best_idx_c;
    logic signed [SCORE_BITS-1:0]  best_score_c;
    logic signed [SCORE_BITS-1:0]  second_score_c;
    wide_t                         margin_c;
    logic                          accept_c;
    logic                          same_c;

    // Free-running frame timer, independent of the FSM
    assign tick_c = (tmr_q == TIMER_BITS'(TIMER_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q <= '0;
        end else if (tick_c) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + TIMER_BITS'(1);
        end
    end

    // Source selection is re-read only while idle; mid-frame the latched choice
    // decides which trigger counts as an overrun.
    assign use_ext_c = (state_q == ST_IDLE) ? frame_src_ext : src_sel_q;
    assign trig_c    = use_ext_c ? frame_trigger : tick_c;
    assign start_c   = (state_q == ST_IDLE) && trig_c;

    // Marks which cycles carry a returned sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= en_q;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign val_s = {1'b0, ts_read_value};

    // Energy accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            energy_q <= '0;
        end else if (start_c) begin
            energy_q <= '0;
        end else if (vld_q[READ_LATENCY-1]) begin
            energy_q <= SCORE_BITS'(sat_add(wide_t'(energy_q), wide_t'(val_s), SCORE_BITS));
        end
    end

    // One saturating MAC lane per class
    for (genvar c = 0; c < int'(NUM_CLASSES); c++) begin : g_lane
        logic signed [WEIGHT_BITS-1:0] w_s;
        logic signed [SCORE_BITS-1:0]  acc_q;
        wide_t                         prod_c;

        assign w_s    = w_data_flat[c*WEIGHT_BITS +: WEIGHT_BITS];
        assign prod_c = wide_t'(val_s) * wide_t'(w_s);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q <= '0;
            end else if (start_c) begin
                acc_q <= '0;
            end else if (vld_q[READ_LATENCY-1]) begin
                acc_q <= SCORE_BITS'(sat_add(wide_t'(acc_q), prod_c, SCORE_BITS));
            end
        end

        assign score_c[c] = acc_q;
    end

    // Score of the class currently being ranked
    always_comb begin
        rank_score_c = '0;
        for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            if (rank_idx_q == CLASS_BITS'(i)) begin
                rank_score_c = score_c[i];
            end
        end
    end

    score_rank_top2 #(
        .SCORE_BITS (SCORE_BITS),
        .CLASS_BITS (CLASS_BITS)
    ) u_rank (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (start_c),
        .valid_i        (state_q == ST_RANK),
        .idx_i          (rank_idx_q),
        .score_i        (rank_score_c),
        .best_idx_o     (best_idx_c),
        .best_score_o   (best_score_c),
        .second_score_o (second_score_c)
    );

    assign margin_c = wide_t'(best_score_c) - wide_t'(second_score_c);
    assign accept_c = (wide_t'(energy_q) >= wide_t'(MIN_ENERGY)) &&
                      (margin_c >= wide_t'(MIN_MARGIN));
    // Streak continues only if the previous accepted frame chose the same class
    assign same_c   = (streak_q != '0) && (best_idx_c == last_class_q);

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        en_d         = 1'b0;
        busy_d       = busy_q;
        drain_d      = drain_q;
        rank_idx_d   = rank_idx_q;
        src_sel_d    = src_sel_q;
        overrun_d    = 1'b0;
        rv_d         = 1'b0;
        rcls_d       = rcls_q;
        rmargin_d    = rmargin_q;
        gv_d         = 1'b0;
        gcls_d       = gcls_q;
        gconf_d      = gconf_q;
        energy_dbg_d = energy_dbg_q;
        scores_dbg_d = scores_dbg_q;
        streak_d     = streak_q;
        last_class_d = last_class_q;

        if ((state_q != ST_IDLE) && trig_c) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                src_sel_d = frame_src_ext;
                if (trig_c) begin
                    state_d = ST_SCAN;
                    addr_d  = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_BITS'(1);
                    en_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Last sample lands READ_LATENCY cycles after the final address
                if (drain_q == DRAIN_BITS'(READ_LATENCY)) begin
                    state_d    = ST_RANK;
                    rank_idx_d = '0;
                end else begin
                    drain_d = drain_q + DRAIN_BITS'(1);
                end
            end
            ST_RANK: begin
                if (rank_idx_q == LAST_CLASS) begin
                    state_d = ST_DECIDE;
                end else begin
                    rank_idx_d = rank_idx_q + CLASS_BITS'(1);
                end
            end
            ST_DECIDE: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                rv_d         = 1'b1;
                rcls_d       = best_idx_c;
                rmargin_d    = clip_margin(margin_c);
                energy_dbg_d = energy_q;
                for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                    scores_dbg_d[i*SCORE_BITS +: SCORE_BITS] = score_c[i];
                end
                if (accept_c) begin
                    last_class_d = best_idx_c;
                    if (same_c) begin
                        streak_d = (streak_q >= STABLE_N) ? streak_q : streak_q + STREAK_BITS'(1);
                    end else begin
                        streak_d = STREAK_BITS'(1);
                    end
                    // Fire once on reaching the threshold; a threshold of one fires every frame
                    if ((streak_d == STABLE_N) && ((STABLE_FRAMES == 1) || (streak_q != STABLE_N))) begin
                        gv_d    = 1'b1;
                        gcls_d  = best_idx_c;
                        gconf_d = clip_margin(margin_c);
                    end
                end else begin
                    streak_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            drain_q      <= '0;
            rank_idx_q   <= '0;
            src_sel_q    <= 1'b0;
            overrun_q    <= 1'b0;
            rv_q         <= 1'b0;
            rcls_q       <= '0;
            rmargin_q    <= '0;
            gv_q         <= 1'b0;
            gcls_q       <= '0;
            gconf_q      <= '0;
            energy_dbg_q <= '0;
            scores_dbg_q <= '0;
            streak_q     <= '0;
            last_class_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            drain_q      <= drain_d;
            rank_idx_q   <= rank_idx_d;
            src_sel_q    <= src_sel_d;
            overrun_q    <= overrun_d;
            rv_q         <= rv_d;
            rcls_q       <= rcls_d;
            rmargin_q    <= rmargin_d;
            gv_q         <= gv_d;
            gcls_q       <= gcls_d;
            gconf_q      <= gconf_d;
            energy_dbg_q <= energy_dbg_d;
            scores_dbg_q <= scores_dbg_d;
            streak_q     <= streak_d;
            last_class_q <= last_class_d;
        end
    end

    assign ts_read_addr       = addr_q;
    assign w_addr             = addr_q;
    assign ts_read_enable     = en_q;
    assign busy               = busy_q;
    assign frame_overrun      = overrun_q;
    assign result_valid       = rv_q;
    assign result_class       = rcls_q;
    assign result_margin      = rmargin_q;
    assign gesture_valid      = gv_q;
    assign gesture_class      = gcls_q;
    assign gesture_confidence = gconf_q;
    assign dbg_energy         = energy_dbg_q;
    assign dbg_scores_flat    = scores_dbg_q;

endmodule

// File: tb/tb_gesture_score_engine.sv
// Bench for gesture_score_engine: a frame table replayed in order through a
// scoreboard queue, plus overrun, mid-frame reset and saturation sequences.
module tb_gesture_score_engine;

    localparam int GS  = 4;
    localparam int NC  = 4;
    localparam int AB  = 4;
    localparam int SB  = 24;
    localparam int SBS = 12;
    localparam int CB  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic frame_src_ext;
    logic frame_trigger;

    logic [AB-1:0]    ts_read_addr;
    logic             ts_read_enable;
    logic [7:0]       ts_read_value;
    logic [AB-1:0]    w_addr;
    logic [NC*8-1:0]  w_data_flat;
    logic             busy;
    logic             frame_overrun;
    logic             result_valid;
    logic [CB-1:0]    result_class;
    logic [7:0]       result_margin;
    logic             gesture_valid;
    logic [CB-1:0]    gesture_class;
    logic [7:0]       gesture_confidence;
    logic [SB-1:0]    dbg_energy;
    logic [NC*SB-1:0] dbg_scores_flat;

    // Saturation instance: narrow scores, internal 30-cycle timer, constant data
    logic [AB-1:0]     s_addr;
    logic              s_en;
    logic [AB-1:0]     s_waddr;
    logic              s_busy;
    logic              s_overrun;
    logic              s_rv;
    logic [CB-1:0]     s_rcls;
    logic [7:0]        s_rmargin;
    logic              s_gv;
    logic [CB-1:0]     s_gcls;
    logic [7:0]        s_gconf;
    logic [SBS-1:0]    s_energy;
    logic [NC*SBS-1:0] s_scores;

    gesture_score_engine #(
        .CLK_FREQ_HZ(12_000_000), .FRAME_PERIOD_MS(10), .GRID_SIZE(GS), .ADDR_BITS(AB),
        .VALUE_BITS(8), .WEIGHT_BITS(8), .SCORE_BITS(SB), .NUM_CLASSES(NC), .CLASS_BITS(CB),
        .READ_LATENCY(2), .MIN_ENERGY(100), .MIN_MARGIN(10), .STABLE_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .frame_src_ext(frame_src_ext), .frame_trigger(frame_trigger),
        .ts_read_addr(ts_read_addr), .ts_read_enable(ts_read_enable), .ts_read_value(ts_read_value),
        .w_addr(w_addr), .w_data_flat(w_data_flat), .busy(busy), .frame_overrun(frame_overrun),
        .result_valid(result_valid), .result_class(result_class), .result_margin(result_margin),
        .gesture_valid(gesture_valid), .gesture_class(gesture_class),
        .gesture_confidence(gesture_confidence), .dbg_energy(dbg_energy),
        .dbg_scores_flat(dbg_scores_flat)
    );

    gesture_score_engine #(
        .CLK_FREQ_HZ(3000), .FRAME_PERIOD_MS(10), .GRID_SIZE(GS), .ADDR_BITS(AB),
        .VALUE_BITS(8), .WEIGHT_BITS(8), .SCORE_BITS(SBS), .NUM_CLASSES(NC), .CLASS_BITS(CB),
        .READ_LATENCY(2), .MIN_ENERGY(100), .MIN_MARGIN(10), .STABLE_FRAMES(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .frame_src_ext(1'b0), .frame_trigger(1'b0),
        .ts_read_addr(s_addr), .ts_read_enable(s_en), .ts_read_value(8'hFF),
        .w_addr(s_waddr), .w_data_flat({NC{8'h7F}}), .busy(s_busy), .frame_overrun(s_overrun),
        .result_valid(s_rv), .result_class(s_rcls), .result_margin(s_rmargin),
        .gesture_valid(s_gv), .gesture_class(s_gcls), .gesture_confidence(s_gconf),
        .dbg_energy(s_energy), .dbg_scores_flat(s_scores)
    );

    // Two-stage read model for surface and weights
    logic [7:0]       surf [GS*GS];
    logic [7:0]       wcls [NC];
    logic [7:0]       p1_v;
    logic [NC*8-1:0]  p1_w;
    logic [NC*8-1:0]  p2_w;

    always @(posedge clk) begin
        p1_v          <= surf[ts_read_addr];
        ts_read_value <= p1_v;
        p1_w          <= {wcls[3], wcls[2], wcls[1], wcls[0]};
        p2_w          <= p1_w;
    end
    assign w_data_flat = p2_w;

    typedef struct {
        int kind;     // 0 plain, 1 overrun during scan, 2 aborted frame first
        int pat;      // 0 all 10, 1 every fifth cell 30, 2 value = index
        int w  [4];
        int cls;
        int margin;
        int energy;
        int sc [4];
        int gv;
        int gcls;
        int gconf;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];
    vec_t exp_q [$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic load_frame(input int pat, input int w[4]);
        for (int i = 0; i < GS*GS; i++) begin
            case (pat)
                0:       surf[i] = 8'd10;
                1:       surf[i] = ((i % 5) == 4) ? 8'd30 : 8'd0;
                default: surf[i] = 8'(i);
            endcase
        end
        for (int c = 0; c < NC; c++) begin
            wcls[c] = 8'(w[c]);
        end
    endtask

    // Start a frame, then reset mid-scan; no result may follow.
    task automatic abort_frame();
        int rv_seen;
        @(negedge clk); frame_trigger = 1'b1;
        @(negedge clk); frame_trigger = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_en", ts_read_enable, 0);
        check("abort_addr", ts_read_addr, 0);
        check("abort_class", result_class, 0);
        check("abort_margin", result_margin, 0);
        check("abort_gclass", gesture_class, 0);
        check("abort_energy", dbg_energy, 0);
        check("abort_scores", (dbg_scores_flat == '0) ? 1 : 0, 1);
        @(negedge clk); rst = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (result_valid) rv_seen++;
        end
        check("abort_no_result", rv_seen, 0);
    endtask

    task automatic run_frame(input vec_t v);
        vec_t e;
        int   n;
        bit   seen;
        int   gcount;
        load_frame(v.pat, v.w);
        if (v.kind == 2) abort_frame();
        exp_q.push_back(v);
        @(negedge clk); frame_trigger = 1'b1;
        @(negedge clk); frame_trigger = 1'b0;
        n = 0; seen = 1'b0; gcount = 0;
        check("busy_rise", busy, 1);
        while (!seen && n < 40) begin
            if (n == 3) check("scan_addr3", ts_read_addr, 3);
            if (v.kind == 1 && n == 4) frame_trigger = 1'b1;
            if (v.kind == 1 && n == 5) begin
                frame_trigger = 1'b0;
                check("overrun_pulse", frame_overrun, 1);
            end
            if (v.kind == 1 && n == 6) check("overrun_clear", frame_overrun, 0);
            if (gesture_valid) gcount++;
            if (result_valid) begin
                seen = 1'b1;
                check("sb_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("latency", n, 24);
                    check("result_class", result_class, e.cls);
                    check("result_margin", result_margin, e.margin);
                    check("dbg_energy", dbg_energy, e.energy);
                    for (int c = 0; c < NC; c++) begin
                        check($sformatf("score%0d", c), $signed(dbg_scores_flat[c*SB +: SB]), e.sc[c]);
                    end
                    check("gesture_count", gcount, e.gv);
                    if (e.gv != 0) begin
                        check("gesture_class", gesture_class, e.gcls);
                        check("gesture_conf", gesture_confidence, e.gconf);
                    end
                end
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL result_timeout: got no result_valid expected one within 40 cycles");
        end
        @(negedge clk);
        check("rv_one_cycle", result_valid, 0);
        check("busy_fall", busy, 0);
    endtask

    initial begin
        int  n;
        bit  seen;
        int  wz[4];

        rst           = 1'b1;
        frame_src_ext = 1'b1;
        frame_trigger = 1'b0;
        wz            = '{0, 0, 0, 0};
        load_frame(0, wz);

        //           kind pat  weights          cls mrg  energy scores              gv gcls gconf
        tbl[0]  = '{0, 0, '{0, 0, 1, 0},  2, 160, 160, '{0, 0, 160, 0},      0, 0, 0};
        tbl[1]  = '{0, 0, '{0, 0, 1, 0},  2, 160, 160, '{0, 0, 160, 0},      1, 2, 160};
        tbl[2]  = '{0, 0, '{0, 0, 1, 0},  2, 160, 160, '{0, 0, 160, 0},      0, 0, 0};
        tbl[3]  = '{0, 0, '{1, 1, 1, 1},  0, 0,   160, '{160, 160, 160, 160}, 0, 0, 0};
        tbl[4]  = '{0, 0, '{0, 0, 1, 0},  2, 160, 160, '{0, 0, 160, 0},      0, 0, 0};
        tbl[5]  = '{0, 1, '{0, 0, 1, 0},  2, 90,  90,  '{0, 0, 90, 0},       0, 0, 0};
        tbl[6]  = '{0, 0, '{0, 0, 1, 0},  2, 160, 160, '{0, 0, 160, 0},      0, 0, 0};
        tbl[7]  = '{0, 0, '{0, 2, 0, 0},  1, 255, 160, '{0, 320, 0, 0},      0, 0, 0};
        tbl[8]  = '{0, 0, '{0, 2, 0, 0},  1, 255, 160, '{0, 320, 0, 0},      1, 1, 255};
        tbl[9]  = '{0, 2, '{-1, 3, 2, 0}, 1, 120, 120, '{-120, 360, 240, 0}, 0, 0, 0};
        tbl[10] = '{1, 0, '{0, 0, 1, 0},  2, 160, 160, '{0, 0, 160, 0},      0, 0, 0};
        tbl[11] = '{2, 0, '{0, 0, 1, 0},  2, 160, 160, '{0, 0, 160, 0},      0, 0, 0};
        tbl[12] = '{0, 0, '{0, 0, 1, 0},  2, 160, 160, '{0, 0, 160, 0},      1, 2, 160};

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_en", ts_read_enable, 0);
        check("rst_overrun", frame_overrun, 0);
        check("rst_rv", result_valid, 0);
        check("rst_class", result_class, 0);
        check("rst_margin", result_margin, 0);
        check("rst_gv", gesture_valid, 0);
        check("rst_energy", dbg_energy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_frame(tbl[i]);
        end

        // Saturating instance: every lane and energy clamp at +2047
        n = 0; seen = 1'b0;
        while (!seen && n < 120) begin
            if (s_rv) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("sat_result_seen", seen, 1);
        check("sat_energy", s_energy, 2047);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("sat_score%0d", c), $signed(s_scores[c*SBS +: SBS]), 2047);
        end
        check("sat_class", s_rcls, 0);
        check("sat_margin", s_rmargin, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
